// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready bundle for pipelined_barrel_shifter.
//
// Upstream side : in_valid, in_ready, in_data, in_shamt, in_mode, in_tag
// Downstream side: out_valid, out_ready, out_data, out_tag
//                  out_sticky (only when SHIFT_STICKY_EN is defined)
//
// master: the environment driving operations in and taking results out.
// slave : the shifter itself.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  localparam int unsigned LOG2W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [LOG2W-1:0]   in_shamt;
  logic [1:0]         in_mode;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;
`ifdef SHIFT_STICKY_EN
  logic               out_sticky;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_sticky
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_sticky
  );
`else
  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
`endif

endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL / SRL / SRA / ROR on a WIDTH-bit operand.
//
// A log2(WIDTH)-level shift network (largest shift first) is cut by a register
// after every REG_EVERY levels, giving LAT = ceil(LOG2W / REG_EVERY) stages. The
// last stage register drives the output directly. Each stage carries its data,
// the shift amount, the mode and the tag; bubbles compress toward the output.
//
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset, clears every stage
//   bus     - pipelined_barrel_shifter_if.slave (in_* request side, out_* result side)
//
// Build option: define SHIFT_STICKY_EN to add bus.out_sticky, set when any 1 bit was
// shifted out of the LSB end by an SRL or SRA operation.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_EVERY = 2,
  parameter int unsigned TAG_W     = 5
) (
  input logic                       clock,
  input logic                       reset_n,
  pipelined_barrel_shifter_if.slave bus
);

  localparam int unsigned LOG2W = $clog2(WIDTH);
  localparam int unsigned LAT   = (LOG2W + REG_EVERY - 1) / REG_EVERY;

  localparam logic [1:0] ModeSll = 2'b00;
  localparam logic [1:0] ModeSrl = 2'b01;
  localparam logic [1:0] ModeSra = 2'b10;
  localparam logic [1:0] ModeRor = 2'b11;

`ifdef SHIFT_STICKY_EN
  localparam int unsigned ResW = WIDTH + 1;
`else
  localparam int unsigned ResW = WIDTH;
`endif

  // Applies levels hi..lo (largest first). In the sticky build the MSB of the
  // result is the OR of every bit dropped by a right shift within these levels.
  function automatic logic [ResW-1:0] shift_group(input logic [WIDTH-1:0] d,
                                                  input logic [LOG2W-1:0] sh,
                                                  input logic [1:0]       mode,
                                                  input int               hi,
                                                  input int               lo);
    logic [WIDTH-1:0] r;
`ifdef SHIFT_STICKY_EN
    logic st;
    st = 1'b0;
`endif
    r = d;
    for (int j = int'(LOG2W) - 1; j >= 0; j--) begin
      if (j <= hi && j >= lo && sh[j]) begin
`ifdef SHIFT_STICKY_EN
        if (mode == ModeSrl || mode == ModeSra) begin
          st = st | (|(r & ({WIDTH{1'b1}} >> (WIDTH - (1 << j)))));
        end
`endif
        unique case (mode)
          ModeSll: r = r << (1 << j);
          ModeSrl: r = r >> (1 << j);
          // The MSB is never disturbed by earlier SRA levels, so it is still
          // the operand's original sign bit.
          ModeSra: r = $signed(r) >>> (1 << j);
          ModeRor: r = (r >> (1 << j)) | (r << (WIDTH - (1 << j)));
        endcase
      end
    end
`ifdef SHIFT_STICKY_EN
    return {st, r};
`else
    return r;
`endif
  endfunction

  // Stage registers; index LAT-1 is the output slot.
  logic [LAT-1:0]   valid_q;
  logic [WIDTH-1:0] data_q  [LAT];
  logic [LOG2W-1:0] shamt_q [LAT];
  logic [1:0]       mode_q  [LAT];
  logic [TAG_W-1:0] tag_q   [LAT];

  // Per-stage source (stage k-1 or the input port) and shift result.
  logic [LAT-1:0]   src_valid;
  logic [WIDTH-1:0] src_data  [LAT];
  logic [LOG2W-1:0] src_shamt [LAT];
  logic [1:0]       src_mode  [LAT];
  logic [TAG_W-1:0] src_tag   [LAT];
  logic [ResW-1:0]  res_d     [LAT];
  logic [LAT-1:0]   load;

`ifdef SHIFT_STICKY_EN
  logic             sticky_q   [LAT];
  logic             src_sticky [LAT];
`endif

  // Stage k loads when it is empty or its contents move on this cycle. The
  // chain starts at out_ready, so in_ready is combinational on it when full.
  always_comb begin
    logic take;
    load = '0;
    take = bus.out_ready;
    for (int k = int'(LAT) - 1; k >= 0; k--) begin
      load[k] = !valid_q[k] || take;
      take    = load[k];
    end
  end

  always_comb begin
    int hi;
    int lo;
    src_valid    = '0;
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.in_data;
    src_shamt[0] = bus.in_shamt;
    src_mode[0]  = bus.in_mode;
    src_tag[0]   = bus.in_tag;
`ifdef SHIFT_STICKY_EN
    src_sticky[0] = 1'b0;
`endif
    for (int k = 1; k < int'(LAT); k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_tag[k]   = tag_q[k-1];
`ifdef SHIFT_STICKY_EN
      src_sticky[k] = sticky_q[k-1];
`endif
    end
    for (int k = 0; k < int'(LAT); k++) begin
      hi = int'(LOG2W) - 1 - k * int'(REG_EVERY);
      lo = hi - int'(REG_EVERY) + 1;
      if (lo < 0) lo = 0;
      res_d[k] = shift_group(src_data[k], src_shamt[k], src_mode[k], hi, lo);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int k = 0; k < int'(LAT); k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
        tag_q[k]   <= '0;
`ifdef SHIFT_STICKY_EN
        sticky_q[k] <= 1'b0;
`endif
      end
    end else begin
      for (int k = 0; k < int'(LAT); k++) begin
        if (load[k]) begin
          valid_q[k] <= src_valid[k];
          // Payload only moves with a real operation; bubbles leave it alone.
          if (src_valid[k]) begin
            data_q[k]  <= res_d[k][WIDTH-1:0];
            shamt_q[k] <= src_shamt[k];
            mode_q[k]  <= src_mode[k];
            tag_q[k]   <= src_tag[k];
`ifdef SHIFT_STICKY_EN
            sticky_q[k] <= src_sticky[k] | res_d[k][WIDTH];
`endif
          end
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid_q[LAT-1];
  assign bus.out_data  = data_q[LAT-1];
  assign bus.out_tag   = tag_q[LAT-1];
`ifdef SHIFT_STICKY_EN
  assign bus.out_sticky = sticky_q[LAT-1];
`endif

endmodule
